// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared hazard tag types, bubble constant and saturating decrement
package pipe_pkg;
    localparam int REG_AW = 5;
    localparam int TNEW_W = 2;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic              we;
        logic [TNEW_W-1:0] tnew;
    } hazard_tag_t;

    localparam hazard_tag_t BUBBLE_TAG = '0;

    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] x);
        return (x == '0) ? '0 : x - 1'b1;
    endfunction
endpackage

// File: rtl/hazard_tag_reg.sv
// rtl/hazard_tag_reg.sv - one pipeline stage register for a hazard tag
module hazard_tag_reg
    import pipe_pkg::*;
#(
    parameter bit DEC = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  hazard_tag_t d,
    output hazard_tag_t q
);
    hazard_tag_t tag_d;
    hazard_tag_t tag_q;

    always_comb begin
        tag_d = d;
        if (DEC) begin
            tag_d.tnew = sat_dec(d.tnew);
        end
        // $0 is never a producer, so its write enable is dropped on entry
        if (d.addr == '0) begin
            tag_d.we = 1'b0;
        end
        if (clr) begin
            tag_d = BUBBLE_TAG;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q <= BUBBLE_TAG;
        end else begin
            tag_q <= tag_d;
        end
    end

    assign q = tag_q;
endmodule

// File: rtl/hazard_tag_pipe.sv
// rtl/hazard_tag_pipe.sv - carries hazard tags E->M->W, applies stall, counts stall cycles
module hazard_tag_pipe
    import pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [REG_AW-1:0] D_WriteRegAddr,
    input  logic              D_RegWrite,
    input  logic [TNEW_W-1:0] D_T_new,
    output logic [REG_AW-1:0] E_WriteRegAddr,
    output logic              E_CU_EN_RegWrite,
    output logic [TNEW_W-1:0] E_T_new,
    output logic [REG_AW-1:0] M_WriteRegAddr,
    output logic              M_CU_EN_RegWrite,
    output logic [TNEW_W-1:0] M_T_new,
    output logic [REG_AW-1:0] W_WriteRegAddr,
    output logic              W_CU_EN_RegWrite,
    output logic [TNEW_W-1:0] W_T_new,
    output logic              PC_en,
    output logic              D_en,
    output logic              E_clr,
    output logic [CNT_W-1:0]  stall_cnt
);
    hazard_tag_t d_tag;
    hazard_tag_t e_tag;
    hazard_tag_t m_tag;
    hazard_tag_t w_tag;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;

    always_comb begin
        d_tag.addr = D_WriteRegAddr;
        d_tag.we   = D_RegWrite;
        d_tag.tnew = D_T_new;
    end

    hazard_tag_reg #(.DEC(1'b0)) u_e_reg (
        .clk(clk), .reset(reset), .clr(stall), .d(d_tag), .q(e_tag)
    );
    hazard_tag_reg #(.DEC(1'b1)) u_m_reg (
        .clk(clk), .reset(reset), .clr(1'b0), .d(e_tag), .q(m_tag)
    );
    hazard_tag_reg #(.DEC(1'b1)) u_w_reg (
        .clk(clk), .reset(reset), .clr(1'b0), .d(m_tag), .q(w_tag)
    );

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign PC_en = ~stall;
    assign D_en  = ~stall;
    assign E_clr = stall;

    assign E_WriteRegAddr   = e_tag.addr;
    assign E_CU_EN_RegWrite = e_tag.we;
    assign E_T_new          = e_tag.tnew;
    assign M_WriteRegAddr   = m_tag.addr;
    assign M_CU_EN_RegWrite = m_tag.we;
    assign M_T_new          = m_tag.tnew;
    assign W_WriteRegAddr   = w_tag.addr;
    assign W_CU_EN_RegWrite = w_tag.we;
    assign W_T_new          = w_tag.tnew;
    assign stall_cnt        = stall_cnt_q;
endmodule

// File: tb/tb_hazard_tag_pipe.sv
// tb/tb_hazard_tag_pipe.sv - directed and random checks of hazard_tag_pipe against a history model
module tb_hazard_tag_pipe;
    logic       clk = 1'b0;
    logic       reset, stall;
    logic [4:0] d_addr;
    logic       d_we;
    logic [1:0] d_tnew;

    logic [4:0] e_addr, m_addr, w_addr, e4_addr, m4_addr, w4_addr;
    logic       e_we, m_we, w_we, e4_we, m4_we, w4_we;
    logic [1:0] e_tn, m_tn, w_tn, e4_tn, m4_tn, w4_tn;
    logic       pc_en, d_en, e_clr, pc_en4, d_en4, e_clr4;
    logic [31:0] cnt32;
    logic [3:0]  cnt4;

    int checks = 0;
    int failures = 0;

    typedef struct {int addr; int we; int tnew;} ent_t;
    ent_t hist[$];
    int   stall_total;

    always #5 clk = ~clk;

    hazard_tag_pipe dut (
        .clk(clk), .reset(reset), .stall(stall),
        .D_WriteRegAddr(d_addr), .D_RegWrite(d_we), .D_T_new(d_tnew),
        .E_WriteRegAddr(e_addr), .E_CU_EN_RegWrite(e_we), .E_T_new(e_tn),
        .M_WriteRegAddr(m_addr), .M_CU_EN_RegWrite(m_we), .M_T_new(m_tn),
        .W_WriteRegAddr(w_addr), .W_CU_EN_RegWrite(w_we), .W_T_new(w_tn),
        .PC_en(pc_en), .D_en(d_en), .E_clr(e_clr), .stall_cnt(cnt32)
    );

    hazard_tag_pipe #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .stall(stall),
        .D_WriteRegAddr(d_addr), .D_RegWrite(d_we), .D_T_new(d_tnew),
        .E_WriteRegAddr(e4_addr), .E_CU_EN_RegWrite(e4_we), .E_T_new(e4_tn),
        .M_WriteRegAddr(m4_addr), .M_CU_EN_RegWrite(m4_we), .M_T_new(m4_tn),
        .W_WriteRegAddr(w4_addr), .W_CU_EN_RegWrite(w4_we), .W_T_new(w4_tn),
        .PC_en(pc_en4), .D_en(d_en4), .E_clr(e_clr4), .stall_cnt(cnt4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected tag for an entry that has spent 'age' edges past E.
    function automatic logic [7:0] exp_tag(input ent_t e, input int age);
        int t;
        t = e.tnew - age;
        if (t < 0) t = 0;
        return {e.addr[4:0], e.we[0], t[1:0]};
    endfunction

    task automatic check_regs(input string tag);
        chk({tag, "_E"}, {e_addr, e_we, e_tn}, exp_tag(hist[2], 0));
        chk({tag, "_M"}, {m_addr, m_we, m_tn}, exp_tag(hist[1], 1));
        chk({tag, "_W"}, {w_addr, w_we, w_tn}, exp_tag(hist[0], 2));
        chk({tag, "_E4"}, {e4_addr, e4_we, e4_tn}, exp_tag(hist[2], 0));
        chk({tag, "_W4"}, {w4_addr, w4_we, w4_tn}, exp_tag(hist[0], 2));
        chk({tag, "_cnt"}, cnt32, stall_total);
        chk({tag, "_cnt4"}, cnt4, (stall_total > 15) ? 15 : stall_total);
    endtask

    task automatic step(input string tag, input logic rst, input logic stl,
                        input int addr, input int we, input int tnew);
        ent_t e;
        @(negedge clk);
        reset  = rst;
        stall  = stl;
        d_addr = addr[4:0];
        d_we   = we[0];
        d_tnew = tnew[1:0];
        #1;
        chk({tag, "_comb"}, {pc_en, d_en, e_clr, pc_en4, d_en4, e_clr4},
            {~stl, ~stl, stl, ~stl, ~stl, stl});
        @(posedge clk);
        if (rst) begin
            hist.delete();
            e = '{0, 0, 0};
            repeat (3) hist.push_back(e);
            stall_total = 0;
        end else begin
            if (stl) begin
                e = '{0, 0, 0};
                stall_total++;
            end else begin
                e = '{addr, (addr != 0 && we != 0) ? 1 : 0, tnew};
            end
            hist.push_back(e);
            void'(hist.pop_front());
        end
        #1;
        check_regs(tag);
    endtask

    initial begin
        ent_t z;
        z = '{0, 0, 0};
        repeat (3) hist.push_back(z);
        stall_total = 0;
        reset = 1'b1; stall = 1'b1; d_addr = '0; d_we = 1'b0; d_tnew = '0;

        step("rst0", 1, 1, 7, 1, 2);
        step("rst1", 1, 1, 7, 1, 2);
        chk("rst_all_zero", {e_addr, e_we, e_tn, m_addr, m_we, m_tn, w_addr, w_we, w_tn, cnt32}, '0);

        step("t2_d", 0, 0, 3, 1, 2);
        chk("t2_E_const", {e_addr, e_we, e_tn}, {5'd3, 1'b1, 2'd2});
        step("t3_stall", 0, 1, 9, 1, 1);
        chk("t3_E_bubble", {e_addr, e_we, e_tn}, 8'h00);
        chk("t3_M_const", {m_addr, m_we, m_tn}, {5'd3, 1'b1, 2'd1});
        chk("t3_cnt_const", cnt32, 32'd1);
        step("t2_w", 0, 0, 0, 1, 1);
        chk("t2_W_const", {w_addr, w_we, w_tn}, {5'd3, 1'b1, 2'd0});
        chk("t4_E_const", {e_addr, e_we, e_tn}, {5'd0, 1'b0, 2'd1});

        for (int i = 0; i < 20; i++) step("t5_long", 0, 1, i, 1, 2);
        chk("t5_cnt4_sat", cnt4, 4'd15);
        chk("t5_bubbles", {e_addr, e_we, e_tn, m_addr, m_we, m_tn, w_addr, w_we, w_tn}, '0);

        step("t6_a", 0, 0, 12, 1, 2);
        step("t6_b", 0, 1, 13, 1, 2);
        step("t6_rst", 1, 1, 14, 1, 2);
        step("t6_c", 0, 0, 15, 1, 1);
        step("t6_d", 0, 0, 16, 0, 2);
        step("t6_e", 0, 0, 17, 1, 0);

        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0),
                 $urandom_range(0, 31), $urandom_range(0, 1), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
